// File: rtl/ikbd_pkg.sv
// Shared types and helpers for the IKBD port 0 sequencer.
package ikbd_pkg;

  typedef enum logic {OWN_MOUSE, OWN_JOY} port_owner_e;

  // Widest accumulator the helper handles; callers pass their real width.
  localparam int ACC_WMAX = 24;

  typedef struct packed {
    logic                sat;
    logic [ACC_WMAX-1:0] sum;
  } sat_res_t;

  // Quadrature phase to {B,A}; one bit flips per step in either direction.
  function automatic logic [1:0] quad_gray(input logic [1:0] ph);
    case (ph)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      2'd2:    return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Signed add clipped symmetrically to +/-(2**(w-1)-1); sat flags a clip.
  function automatic sat_res_t sat_add(input logic [ACC_WMAX-1:0] acc,
                                       input logic [ACC_WMAX-1:0] delta,
                                       input int w);
    logic signed [ACC_WMAX:0] s, lim, nlim;
    sat_res_t r;
    s    = $signed({acc[ACC_WMAX-1], acc}) + $signed({delta[ACC_WMAX-1], delta});
    lim  = (ACC_WMAX+1)'((33'd1 << (w - 1)) - 33'd1);
    nlim = -lim;
    r.sat = 1'b0;
    r.sum = s[ACC_WMAX-1:0];
    if (s > lim) begin
      r.sat = 1'b1;
      r.sum = lim[ACC_WMAX-1:0];
    end else if (s < nlim) begin
      r.sat = 1'b1;
      r.sum = nlim[ACC_WMAX-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ikbd_quad_axis.sv
// One mouse axis: saturating step accumulator feeding a quadrature phase counter.
module ikbd_quad_axis
  import ikbd_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic       clk,
  input  logic       res,
  input  logic       tick,
  input  logic       load_en,
  input  logic       clear,
  input  logic       run,
  input  logic [9:0] delta,
  output logic [1:0] gray,
  output logic       sat
);

  logic [ACC_W-1:0]        acc_q, acc_d, base;
  logic signed [ACC_W-1:0] acc_s;
  logic [1:0]              ph_q, ph_d;
  sat_res_t                sr;

  // Add the new delta, then step one unit toward zero; direction uses the pre-update value.
  always_comb begin
    acc_s = $signed(acc_q);
    sr    = sat_add(ACC_WMAX'(acc_s), ACC_WMAX'($signed(delta)), ACC_W);
    base  = acc_q;
    sat   = 1'b0;
    if (load_en) begin
      base = sr.sum[ACC_W-1:0];
      sat  = sr.sat;
    end
    acc_d = base;
    ph_d  = ph_q;
    if (run && tick && acc_s > 0) begin
      acc_d = base - ACC_W'(1);
      ph_d  = ph_q + 2'd1;
    end else if (run && tick && acc_s < 0) begin
      acc_d = base + ACC_W'(1);
      ph_d  = ph_q - 2'd1;
    end
    if (clear) acc_d = '0;
  end

  // Accumulator and phase state.
  always_ff @(posedge clk) begin
    if (res) begin
      acc_q <= '0;
      ph_q  <= '0;
    end else begin
      acc_q <= acc_d;
      ph_q  <= ph_d;
    end
  end

  assign gray = quad_gray(ph_q);

endmodule

// File: rtl/ikbd_port0_sched.sv
// Port 0 owner arbitration (mouse vs joystick0) and paced mouse quadrature playout.
module ikbd_port0_sched
  import ikbd_pkg::*;
#(
  parameter int STEP_DIV = 500,
  parameter int ACC_W    = 10,
  parameter int HOLD_CYC = 200000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       mouse_strobe,
  input  logic [8:0] mouse_dx,
  input  logic [8:0] mouse_dy,
  input  logic [1:0] mouse_btn,
  input  logic [5:0] joystick0,
  output logic [5:0] port0,
  output logic       mouse_active,
  output logic       acc_sat
);

  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW = $clog2(HOLD_CYC + 1);

  port_owner_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    btn_q, btn_d;
  logic [5:0]    last_joy_q, last_joy_d;
  logic [5:0]    port0_q, port0_d;
  logic          mouse_active_q, mouse_active_d;
  logic          acc_sat_q, acc_sat_d;

  logic       tick, mouse_act, joy_act, reload;
  logic       load_en, clear_acc, run, sat_x, sat_y;
  logic [1:0] gray_x, gray_y;
  logic [9:0] delta_x, delta_y;

  // Atari Y grows downward, PS/2 Y grows upward: negate after widening.
  assign delta_x = {mouse_dx[8], mouse_dx};
  assign delta_y = -{mouse_dy[8], mouse_dy};

  // Step-slot timer and activity detection.
  always_comb begin
    tick       = (timer_q == TW'(STEP_DIV - 1));
    timer_d    = tick ? '0 : timer_q + TW'(1);
    mouse_act  = mouse_strobe && (mouse_dx != '0 || mouse_dy != '0 || mouse_btn != btn_q);
    joy_act    = (joystick0 != last_joy_q);
    btn_d      = mouse_act ? mouse_btn : btn_q;
    last_joy_d = joystick0;
  end

  // Ownership FSM; the current owner's own activity always wins over a takeover.
  always_comb begin
    state_d   = state_q;
    reload    = 1'b0;
    clear_acc = 1'b0;
    load_en   = 1'b0;
    if (state_q == OWN_MOUSE) begin
      load_en = mouse_strobe;
      if (mouse_act) begin
        reload = 1'b1;
      end else if (joy_act && hold_q == '0) begin
        state_d   = OWN_JOY;
        reload    = 1'b1;
        clear_acc = 1'b1;
      end
    end else begin
      if (joy_act) begin
        reload = 1'b1;
      end else if (mouse_act && hold_q == '0) begin
        state_d = OWN_MOUSE;
        reload  = 1'b1;
        load_en = 1'b1;
      end
    end
    hold_d = reload ? HW'(HOLD_CYC) : (hold_q != '0 ? hold_q - HW'(1) : hold_q);
    run    = (state_q == OWN_MOUSE);
  end

  ikbd_quad_axis #(.ACC_W(ACC_W)) u_axis_x (
    .clk(clk), .res(res), .tick(tick), .load_en(load_en), .clear(clear_acc),
    .run(run), .delta(delta_x), .gray(gray_x), .sat(sat_x)
  );

  ikbd_quad_axis #(.ACC_W(ACC_W)) u_axis_y (
    .clk(clk), .res(res), .tick(tick), .load_en(load_en), .clear(clear_acc),
    .run(run), .delta(delta_y), .gray(gray_y), .sat(sat_y)
  );

  // Output mux from the current owner; registered below.
  always_comb begin
    port0_d        = (state_q == OWN_MOUSE) ? {btn_q, gray_y, gray_x} : joystick0;
    mouse_active_d = (state_q == OWN_MOUSE);
    acc_sat_d      = sat_x | sat_y;
  end

  // State and output registers; last_joy samples the live input on reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q        <= OWN_MOUSE;
      timer_q        <= '0;
      hold_q         <= '0;
      btn_q          <= '0;
      last_joy_q     <= joystick0;
      port0_q        <= '0;
      mouse_active_q <= 1'b1;
      acc_sat_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      hold_q         <= hold_d;
      btn_q          <= btn_d;
      last_joy_q     <= last_joy_d;
      port0_q        <= port0_d;
      mouse_active_q <= mouse_active_d;
      acc_sat_q      <= acc_sat_d;
    end
  end

  assign port0        = port0_q;
  assign mouse_active = mouse_active_q;
  assign acc_sat      = acc_sat_q;

endmodule

// File: tb/tb_ikbd_port0_sched.sv
// Directed + random bench for ikbd_port0_sched against a cycle-level integer model.
module tb_ikbd_port0_sched;

  localparam int SD  = 8;
  localparam int AW  = 10;
  localparam int HC  = 40;
  localparam int LIM = (1 << (AW - 1)) - 1;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       strobe = 1'b0;
  logic [8:0] dx = '0, dy = '0;
  logic [1:0] btn = '0;
  logic [5:0] joy = 6'h01;
  logic [5:0] port0;
  logic       mouse_active, acc_sat;

  always #5 clk = ~clk;

  ikbd_port0_sched #(.STEP_DIV(SD), .ACC_W(AW), .HOLD_CYC(HC)) dut (
    .clk(clk), .res(res), .mouse_strobe(strobe), .mouse_dx(dx), .mouse_dy(dy),
    .mouse_btn(btn), .joystick0(joy), .port0(port0), .mouse_active(mouse_active),
    .acc_sat(acc_sat)
  );

  int n_chk = 0, n_err = 0;

  // Reference model: plain integers for accumulators, phases, timer, hold.
  int       m_ax, m_ay, m_px, m_py, m_tmr, m_hold;
  bit       m_mouse;
  bit [1:0] m_btn;
  bit [5:0] m_ljoy;
  bit [5:0] e_port;
  bit       e_act, e_sat;
  bit [1:0] gtab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clip(input int v, output bit s);
    s = 1'b0;
    if (v > LIM) begin s = 1'b1; return LIM; end
    if (v < -LIM) begin s = 1'b1; return -LIM; end
    return v;
  endfunction

  task automatic model_edge();
    bit tk, ma, ja, ld, sw_j, sw_m, sx, sy;
    int nx, ny;
    if (res) begin
      m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_tmr = 0; m_hold = 0;
      m_mouse = 1'b1; m_btn = 2'b00; m_ljoy = joy;
      e_port = 6'h00; e_act = 1'b1; e_sat = 1'b0;
      return;
    end
    tk    = (m_tmr == SD - 1);
    m_tmr = (m_tmr + 1) % SD;
    ma = strobe && (dx != 0 || dy != 0 || btn != m_btn);
    ja = (joy != m_ljoy);
    e_port = m_mouse ? {m_btn, gtab[m_py], gtab[m_px]} : joy;
    e_act  = m_mouse;
    sw_j = m_mouse && !ma && ja && m_hold == 0;
    sw_m = !m_mouse && !ja && ma && m_hold == 0;
    ld   = strobe && (m_mouse || sw_m);
    nx = m_ax; ny = m_ay; sx = 1'b0; sy = 1'b0;
    if (ld) begin
      nx = clip(m_ax + int'($signed(dx)), sx);
      ny = clip(m_ay - int'($signed(dy)), sy);
    end
    if (m_mouse && tk) begin
      if (m_ax > 0) begin nx--; m_px = (m_px + 1) % 4; end
      else if (m_ax < 0) begin nx++; m_px = (m_px + 3) % 4; end
      if (m_ay > 0) begin ny--; m_py = (m_py + 1) % 4; end
      else if (m_ay < 0) begin ny++; m_py = (m_py + 3) % 4; end
    end
    if (sw_j) begin nx = 0; ny = 0; end
    m_ax = nx; m_ay = ny;
    e_sat = sx | sy;
    if ((m_mouse && ma) || (!m_mouse && ja) || sw_j || sw_m) m_hold = HC;
    else if (m_hold > 0) m_hold--;
    if (sw_j) m_mouse = 1'b0;
    if (sw_m) m_mouse = 1'b1;
    if (ma) m_btn = btn;
    m_ljoy = joy;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("port0", 32'(port0), 32'(e_port));
    chk("mouse_active", 32'(mouse_active), 32'(e_act));
    chk("acc_sat", 32'(acc_sat), 32'(e_sat));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic pulse(input logic [8:0] x, input logic [8:0] y, input logic [1:0] b);
    strobe = 1'b1; dx = x; dy = y; btn = b;
    cyc();
    strobe = 1'b0; dx = '0; dy = '0;
  endtask

  initial begin
    // Reset with joystick held: no spurious takeover on release.
    idle(2);
    res = 1'b0;
    idle(3);
    chk("rst_port0", 32'(port0), 32'h00);
    chk("rst_mouse_active", 32'(mouse_active), 32'h1);

    // dx=+3: three forward X steps ending at phase 3 (10), Y untouched.
    pulse(9'd3, 9'd0, 2'b00);
    idle(3 * SD + 2);
    chk("x_fwd3", 32'(port0[1:0]), 32'h2);
    chk("y_static", 32'(port0[3:2]), 32'h0);

    // dy=+2 (up): Y walks backwards 0->3->2.
    pulse(9'd0, 9'd2, 2'b00);
    idle(2 * SD + 2);
    chk("y_rev2", 32'(port0[3:2]), 32'h3);

    // dx=-1 landing on a tick edge: one reverse X step, 3->2.
    while (m_tmr != SD - 1) cyc();
    pulse(9'h1FF, 9'd0, 2'b00);
    idle(SD + 2);
    chk("x_rev1", 32'(port0[1:0]), 32'h3);

    // Saturation: four max positive deltas back to back.
    for (int k = 0; k < 4; k++) begin
      pulse(9'd255, 9'd0, 2'b00);
      cyc();
    end

    // Joystick moves while hold is live: mouse keeps the port.
    joy = 6'h05;
    idle(2);
    chk("hold_keeps_mouse", 32'(mouse_active), 32'h1);
    idle(HC + 5);
    joy = 6'h0A;
    idle(3);
    chk("joy_takeover", 32'(mouse_active), 32'h0);
    chk("joy_port0", 32'(port0), 32'h0A);

    // Non-active strobe in JOY is ignored; button press after hold expiry returns to mouse.
    pulse(9'd0, 9'd0, 2'b00);
    idle(2);
    chk("joy_ignore_idle", 32'(mouse_active), 32'h0);
    idle(HC + 2);
    pulse(9'd0, 9'd0, 2'b01);
    idle(2);
    chk("mouse_return", 32'(mouse_active), 32'h1);
    chk("mouse_left_btn", 32'(port0[4]), 32'h1);

    // Random traffic with occasional resets; heavy mouse first, then sparse.
    for (int i = 0; i < 4000; i++) begin
      int sp;
      sp  = (i < 2000) ? 5 : 60;
      res = ($urandom_range(999) == 0);
      strobe = ($urandom_range(sp) == 0);
      if ($urandom_range(3) == 0) dx = 9'($urandom);
      else dx = 9'($urandom_range(6)) - 9'd3;
      if ($urandom_range(3) == 0) dy = 9'($urandom);
      else dy = 9'($urandom_range(6)) - 9'd3;
      if ($urandom_range(4) == 0) btn = 2'($urandom_range(3));
      if ($urandom_range(50) == 0) joy = 6'($urandom);
      cyc();
    end
    res = 1'b0; strobe = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
